// File: rtl/loopback_adapter_pkg.sv
// Shared definitions for the Avalon-ST loopback adapter: payload field layout
// and FSM state encoding.
package loopback_adapter_pkg;

    localparam int unsigned PL_ERR  = 0;
    localparam int unsigned PL_EOP  = 1;
    localparam int unsigned PL_SOP  = 2;
    localparam int unsigned PL_DATA = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

endpackage

// File: rtl/loopback_adapter_fifo_p.sv
// Synchronous show-ahead FIFO; wrap-around pointers one bit wider than the
// address so full and empty are distinguishable without a separate flag.
module loopback_adapter_fifo_p #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             pop_ok;

    assign fill_level = wr_ptr - rd_ptr;
    assign full       = (fill_level == (AW+1)'(DEPTH));
    assign pop_ok     = pop && (fill_level != '0);
    assign rd_data    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    push_while_full: assert property (@(posedge clk) disable iff (reset) !(push && full))
        else $fatal(1, "loopback_adapter_fifo_p: push while full");

endmodule

// File: rtl/loopback_adapter_pgen.sv
// Avalon-ST loopback timing adapter: buffers the MAC TX stream and replays it as
// the RX stream, truncating (eop+error) packets that would overflow the FIFO.
module loopback_adapter_pgen
    import loopback_adapter_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ERR_W     = 5,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned READY_THR = 48,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic [ERR_W-1:0]         in_error,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic                     out_error,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int unsigned FW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = DATA_W + 3;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   wr_payload;
    logic [PW-1:0]   rd_payload;
    logic            push;
    logic            pop;
    logic            drop_inc;
    logic            full;
    logic            last_slot;
    logic            start_like;
    logic            write_beat;
    logic            trunc;
    logic            lost;
    logic            err_bit;

    assign full       = (fill_level == FW'(DEPTH));
    assign last_slot  = (fill_level == FW'(DEPTH - 1));
    assign in_ready   = (fill_level < FW'(READY_THR));

    // A SOP seen in DROP resyncs exactly as if the FSM were in IDLE.
    assign start_like = (state == ST_IDLE) || ((state == ST_DROP) && in_startofpacket);
    assign write_beat = in_valid && ((state == ST_PKT) || start_like);
    assign trunc      = write_beat && last_slot && !in_endofpacket;
    // Only reachable after an EOP filled the reserved slot: the beat cannot be stored.
    assign lost       = write_beat && full;
    assign err_bit    = (|in_error) || trunc
                      || ((state == ST_IDLE) && !in_startofpacket)
                      || ((state == ST_PKT)  && in_startofpacket);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (in_valid) begin
            if (trunc || (lost && !in_endofpacket)) begin
                state_nxt = ST_DROP;
            end else if (write_beat) begin
                state_nxt = in_endofpacket ? ST_IDLE : ST_PKT;
            end else if (in_endofpacket) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        wr_payload                  = '0;
        wr_payload[PW-1:PL_DATA]    = in_data;
        wr_payload[PL_SOP]          = in_startofpacket;
        wr_payload[PL_EOP]          = in_endofpacket || trunc;
        wr_payload[PL_ERR]          = err_bit;
        push                        = write_beat && !full;
        drop_inc                    = trunc || lost;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop_inc && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    assign out_valid         = (fill_level != '0);
    assign pop               = out_valid && out_ready;
    assign out_data          = out_valid ? rd_payload[PW-1:PL_DATA] : '0;
    assign out_startofpacket = out_valid && rd_payload[PL_SOP];
    assign out_endofpacket   = out_valid && rd_payload[PL_EOP];
    assign out_error         = out_valid && rd_payload[PL_ERR];

    loopback_adapter_fifo_p #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .wr_data    (wr_payload),
        .pop        (pop),
        .rd_data    (rd_payload),
        .fill_level (fill_level)
    );

endmodule

// File: tb/tb_loopback_adapter_pgen.sv
// Scoreboard bench for loopback_adapter_pgen: stimulus queues expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_loopback_adapter_pgen;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ERR_W  = 5;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned THR    = 48;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_ready;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_startofpacket;
    logic              in_endofpacket;
    logic [ERR_W-1:0]  in_error;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_startofpacket;
    logic              out_endofpacket;
    logic              out_error;
    logic [6:0]        fill_level;
    logic [CNT_W-1:0]  drop_count;

    int errors = 0;
    int checks = 0;
    logic [DATA_W+2:0] exp_q [$];

    loopback_adapter_pgen #(
        .DATA_W    (DATA_W),
        .ERR_W     (ERR_W),
        .DEPTH     (DEPTH),
        .READY_THR (THR),
        .CNT_W     (CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_error          (in_error),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_error         (out_error),
        .fill_level        (fill_level),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_beat(input int d, input bit s, input bit e, input bit er);
        logic [DATA_W+2:0] w;
        w = {d[DATA_W-1:0], s, e, er};
        exp_q.push_back(w);
    endtask

    task automatic drive(input int d, input bit s, input bit e, input logic [ERR_W-1:0] er);
        in_valid         = 1'b1;
        in_data          = d[DATA_W-1:0];
        in_startofpacket = s;
        in_endofpacket   = e;
        in_error         = er;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid         = 1'b0;
        in_data          = '0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_error         = '0;
    endtask

    task automatic drain(input string name);
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (fill_level == 0) break;
            @(posedge clk);
            #1;
        end
        check({name, "_drained"}, int'(fill_level), 0);
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin : monitor
        logic [DATA_W+2:0] got;
        logic [DATA_W+2:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                got = {out_data, out_startofpacket, out_endofpacket, out_error};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: got unexpected beat 0x%0h expected none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL beat: got {data,sop,eop,err}=0x%0h expected 0x%0h", got, exp);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        idle();
        out_ready = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_fill", int'(fill_level), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_drop_count", int'(drop_count), 0);
        check("rst_out_data", int'(out_data), 0);

        // 10-beat packet with a ready sink, one-cycle latency.
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            expect_beat(i, i == 1, i == 10, 1'b0);
            drive(i, i == 1, i == 10, '0);
            if (i == 1) begin
                check("lat_valid", int'(out_valid), 1);
                check("lat_data", int'(out_data), 1);
            end
        end
        drain("t1");
        check("t1_drop_count", int'(drop_count), 0);

        // Backpressure threshold.
        out_ready = 1'b0;
        for (int i = 0; i < 48; i++) begin
            check("t2_in_ready_below", int'(in_ready), 1);
            expect_beat(i + 16, i == 0, i == 47, 1'b0);
            drive(i + 16, i == 0, i == 47, '0);
        end
        idle();
        check("t2_fill48", int'(fill_level), 48);
        check("t2_in_ready_at48", int'(in_ready), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t2_fill47", int'(fill_level), 47);
        check("t2_in_ready_at47", int'(in_ready), 1);
        drain("t2");

        // Overflow: 100-beat packet ignoring in_ready, truncated in the reserved slot.
        out_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i < 63) expect_beat(i, i == 0, 1'b0, 1'b0);
            else if (i == 63) expect_beat(i, 1'b0, 1'b1, 1'b1);
            drive(i, i == 0, i == 99, '0);
        end
        idle();
        check("t3_fill", int'(fill_level), 64);
        check("t3_drop_count", int'(drop_count), 1);
        check("t3_in_ready", int'(in_ready), 0);
        drain("t3a");
        for (int i = 0; i < 5; i++) begin
            expect_beat(8'hA0 + i, i == 0, i == 4, 1'b0);
            drive(8'hA0 + i, i == 0, i == 4, '0);
        end
        drain("t3b");
        check("t3_drop_count_after", int'(drop_count), 1);

        // Error on a middle beat only.
        for (int i = 0; i < 5; i++) begin
            expect_beat(8'h30 + i, i == 0, i == 4, i == 2);
            drive(8'h30 + i, i == 0, i == 4, (i == 2) ? 5'b00100 : 5'b00000);
        end
        drain("t4");

        // Enter DROP via truncation, then resync on SOP; mid-packet SOP flagged.
        out_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i < 63) expect_beat(i + 100, i == 0, 1'b0, 1'b0);
            else if (i == 63) expect_beat(i + 100, 1'b0, 1'b1, 1'b1);
            drive(i + 100, i == 0, 1'b0, '0);
        end
        idle();
        check("t5_drop_count", int'(drop_count), 2);
        drain("t5a");
        drive(8'h77, 1'b0, 1'b0, '0);
        idle();
        @(posedge clk);
        #1;
        check("t5_drop_discard", int'(fill_level), 0);
        expect_beat(8'hB1, 1'b1, 1'b0, 1'b0);
        expect_beat(8'hB2, 1'b0, 1'b0, 1'b0);
        expect_beat(8'hB3, 1'b0, 1'b1, 1'b0);
        drive(8'hB1, 1'b1, 1'b0, '0);
        drive(8'hB2, 1'b0, 1'b0, '0);
        drive(8'hB3, 1'b0, 1'b1, '0);
        expect_beat(8'hC0, 1'b1, 1'b0, 1'b0);
        expect_beat(8'hC1, 1'b0, 1'b0, 1'b0);
        expect_beat(8'hC2, 1'b1, 1'b0, 1'b1);
        expect_beat(8'hC3, 1'b0, 1'b1, 1'b0);
        drive(8'hC0, 1'b1, 1'b0, '0);
        drive(8'hC1, 1'b0, 1'b0, '0);
        drive(8'hC2, 1'b1, 1'b0, '0);
        drive(8'hC3, 1'b0, 1'b1, '0);
        drain("t5b");
        check("t5_drop_count_after", int'(drop_count), 2);

        // Reset mid-packet with 20 words buffered; those words are flushed, not expected.
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(8'hD0 + i, i == 0, 1'b0, '0);
        end
        idle();
        check("t6_fill20", int'(fill_level), 20);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_fill", int'(fill_level), 0);
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_drop_count", int'(drop_count), 0);
        check("t6_in_ready", int'(in_ready), 1);

        // Beat without SOP in IDLE is stored with error set.
        out_ready = 1'b1;
        expect_beat(8'h55, 1'b0, 1'b1, 1'b1);
        drive(8'h55, 1'b0, 1'b1, '0);
        drain("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
